// File: rtl/spinner_pkg.sv
// spinner_pkg: shared types, constants and helpers for the spinner_bank slice.
package spinner_pkg;

  // Per-channel motion mode: free-running spinner or bounded paddle.
  typedef enum logic {
    SPIN_WRAP  = 1'b0,
    SPIN_CLAMP = 1'b1
  } spin_mode_e;

  // Width of one HPS spinner word: [8] sample toggle, [7:0] signed delta.
  localparam int unsigned SPIN_WORD_W = 9;

  // Saturate a sign-extended position sum into [lo, hi].
  function automatic logic signed [31:0] sat_range(input logic signed [31:0] v,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    logic signed [31:0] r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/spinner_lane.sv
// spinner_lane: one channel's position register fed by digital steps and
// HPS analog deltas. Build macro SPINNER_ACCEL_EN enables the ramping step.
module spinner_lane
  import spinner_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned DIG_STEP  = 4,
  parameter int unsigned ANA_SHIFT = 0,
  parameter logic [W-1:0] PAD_MIN   = '0,
  parameter logic [W-1:0] PAD_MAX   = '1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   strobe_rise,
  input  logic                   plus,
  input  logic                   minus,
  input  logic [SPIN_WORD_W-1:0] spin_in,
  input  spin_mode_e             mode,
  output logic [W-1:0]           pos,
  output logic                   moved
);

  // Sum width leaves headroom for pos + digital step + shifted analog delta.
  localparam int unsigned NW = W + 5;

  logic                 t_prev_q;
  logic                 armed_q;
  logic                 ana_ev;
  logic                 upd;
  logic signed [NW-1:0] step;
  logic signed [NW-1:0] dig_delta;
  logic signed [NW-1:0] ana_delta;
  logic signed [NW-1:0] next_val;
  logic [W-1:0]         res;

`ifdef SPINNER_ACCEL_EN
  logic [3:0] accel_q;

  // Ramping step: one count more per consecutive single-direction strobe.
  always_comb step = NW'(accel_q) + NW'(1);

  // Accel counter saturates at DIG_STEP-1, clears on release or both held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accel_q <= '0;
    end else if (strobe_rise) begin
      if (plus ^ minus) begin
        if (accel_q != 4'(DIG_STEP - 1)) accel_q <= accel_q + 4'd1;
      end else begin
        accel_q <= '0;
      end
    end
  end
`else
  // Fixed digital step.
  always_comb step = NW'(DIG_STEP);
`endif

  // Combine both motion sources and apply wrap or clamp.
  always_comb begin
    dig_delta = '0;
    if (strobe_rise) begin
      if (plus && !minus)      dig_delta = step;
      else if (minus && !plus) dig_delta = -step;
    end
    ana_ev    = armed_q && (spin_in[8] != t_prev_q);
    ana_delta = '0;
    if (ana_ev) ana_delta = NW'($signed(spin_in[7:0])) <<< ANA_SHIFT;
    next_val = $signed({5'b0, pos}) + dig_delta + ana_delta;
    if (mode == SPIN_CLAMP)
      res = W'(sat_range(32'(next_val), 32'(PAD_MIN), 32'(PAD_MAX)));
    else
      res = next_val[W-1:0];
    upd = strobe_rise || ana_ev;
  end

  // Position, toggle history, arming and one-cycle moved pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos      <= RESET_VAL;
      t_prev_q <= 1'b0;
      armed_q  <= 1'b0;
      moved    <= 1'b0;
    end else begin
      t_prev_q <= spin_in[8];
      armed_q  <= 1'b1;
      moved    <= 1'b0;
      if (upd) begin
        pos   <= res;
        moved <= (res != pos);
      end
    end
  end

endmodule

// File: rtl/spinner_bank.sv
// spinner_bank: CH-channel spinner/paddle position generator. Shares the
// strobe edge detector and replicates spinner_lane per channel.
// Build macro SPINNER_ACCEL_EN enables the ramping digital step.
module spinner_bank
  import spinner_pkg::*;
#(
  parameter int unsigned CH        = 2,
  parameter int unsigned W         = 8,
  parameter int unsigned DIG_STEP  = 4,
  parameter int unsigned ANA_SHIFT = 0,
  parameter logic [W-1:0] PAD_MIN   = '0,
  parameter logic [W-1:0] PAD_MAX   = '1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      strobe,
  input  logic [CH-1:0]             plus,
  input  logic [CH-1:0]             minus,
  input  logic [SPIN_WORD_W*CH-1:0] spin_in,
  input  logic [CH-1:0]             mode,
  output logic [W*CH-1:0]           spin_out,
  output logic [CH-1:0]             moved
);

  logic strobe_d;
  logic strobe_rise;

  // Delayed strobe for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe_d <= 1'b0;
    else          strobe_d <= strobe;
  end

  // Frame strobe rising edge, shared by all lanes.
  always_comb strobe_rise = strobe & ~strobe_d;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    spinner_lane #(
      .W        (W),
      .DIG_STEP (DIG_STEP),
      .ANA_SHIFT(ANA_SHIFT),
      .PAD_MIN  (PAD_MIN),
      .PAD_MAX  (PAD_MAX),
      .RESET_VAL(RESET_VAL)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .strobe_rise(strobe_rise),
      .plus       (plus[k]),
      .minus      (minus[k]),
      .spin_in    (spin_in[k*SPIN_WORD_W +: SPIN_WORD_W]),
      .mode       (spin_mode_e'(mode[k])),
      .pos        (spin_out[k*W +: W]),
      .moved      (moved[k])
    );
  end

endmodule

// File: tb/tb_spinner_bank.sv
// tb_spinner_bank: table-driven directed vectors, hand-written reset
// sequences and randomized traffic checked against a behavioural model.
module tb_spinner_bank;

  localparam int unsigned CH        = 2;
  localparam int unsigned W         = 8;
  localparam int unsigned DIG_STEP  = 4;
  localparam int unsigned ANA_SHIFT = 1;
  localparam int          PMIN      = 10;
  localparam int          PMAX      = 200;
  localparam int          RV        = 100;
`ifdef SPINNER_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          strobe;
  logic [1:0]    plus, minus, mode;
  logic [17:0]   spin_in;
  logic [15:0]   spin_out;
  logic [1:0]    moved;

  logic [1:0]    tog;
  logic [7:0]    d0, d1;
  int            n_cmp = 0;
  int            n_err = 0;

  spinner_bank #(
    .CH(CH), .W(W), .DIG_STEP(DIG_STEP), .ANA_SHIFT(ANA_SHIFT),
    .PAD_MIN(8'(PMIN)), .PAD_MAX(8'(PMAX)), .RESET_VAL(8'(RV))
  ) dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .plus(plus), .minus(minus),
    .spin_in(spin_in), .mode(mode), .spin_out(spin_out), .moved(moved)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int m_pos [CH];
  int m_acc [CH];
  bit m_tprev [CH];
  bit m_mv [CH];
  bit m_armed;
  bit m_sprev;

  always @(posedge clk or negedge reset_n) begin : model
    int nv, stp, dig, ana, res, dv;
    bit ev, rise;
    if (!reset_n) begin
      for (int k = 0; k < CH; k++) begin
        m_pos[k] <= RV; m_acc[k] <= 0; m_tprev[k] <= 1'b0; m_mv[k] <= 1'b0;
      end
      m_armed <= 1'b0;
      m_sprev <= 1'b0;
    end else begin
      rise = strobe && !m_sprev;
      for (int k = 0; k < CH; k++) begin
        ev  = rise;
        dig = 0;
        ana = 0;
        if (rise) begin
          if (plus[k] != minus[k]) begin
            stp = ACC ? m_acc[k] + 1 : DIG_STEP;
            dig = plus[k] ? stp : -stp;
            m_acc[k] <= (m_acc[k] + 1 > DIG_STEP - 1) ? DIG_STEP - 1 : m_acc[k] + 1;
          end else begin
            m_acc[k] <= 0;
          end
        end
        if (m_armed && (spin_in[k*9+8] != m_tprev[k])) begin
          ev  = 1'b1;
          dv  = $signed(spin_in[k*9 +: 8]);
          ana = dv * (1 << ANA_SHIFT);
        end
        if (ev) begin
          nv = m_pos[k] + dig + ana;
          if (mode[k]) res = (nv < PMIN) ? PMIN : ((nv > PMAX) ? PMAX : nv);
          else         res = ((nv % 256) + 256) % 256;
          m_mv[k]  <= (res != m_pos[k]);
          m_pos[k] <= res;
        end else begin
          m_mv[k] <= 1'b0;
        end
        m_tprev[k] <= spin_in[k*9+8];
      end
      m_armed <= 1'b1;
      m_sprev <= strobe;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [1:0] mode;
    logic       strb;
    logic [1:0] plus;
    logic [1:0] minus;
    logic [1:0] tog;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic [1:0] mv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [1:0] md, input logic st,
                     input logic [1:0] pl, input logic [1:0] mi, input logic [1:0] tg,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] e0, input logic [7:0] e1, input logic [1:0] mv);
    vec_t v;
    v.name = nm; v.mode = md; v.strb = st; v.plus = pl; v.minus = mi; v.tog = tg;
    v.d0 = a0; v.d1 = a1; v.exp0 = e0; v.exp1 = e1; v.mv = mv;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive_spin();
    spin_in = {tog[1], d1, tog[0], d0};
  endtask

  int ramp_acc [6] = '{1, 3, 6, 10, 14, 18};

  initial begin
    reset_n = 1'b1;
    strobe  = 1'b0;
    plus    = '0;
    minus   = '0;
    mode    = '0;
    tog     = 2'b11;
    d0      = 8'd50;
    d1      = 8'd50;
    drive_spin();

    // Reset with toggle bits high: arming cycle must not apply a delta.
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pos", spin_out, {8'(RV), 8'(RV)});
    chk("reset_moved", moved, 2'b00);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arm_pos", spin_out, {8'(RV), 8'(RV)});
    chk("arm_moved", moved, 2'b00);
    @(posedge clk); #1;
    chk("post_arm_pos", spin_out, {8'(RV), 8'(RV)});

    add("pos_to_12",   2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 8'hD4, 8'h00, 8'd12, 8'd100, 2'b01);
    add("clamp_low",   2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 8'hCE, 8'h00, 8'd10, 8'd100, 2'b01);
    add("clamp_noop",  2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 8'hFB, 8'h00, 8'd10, 8'd100, 2'b00);
    add("ana_up",      2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 8'h7A, 8'h00, 8'd254, 8'd100, 2'b01);
    add("wrap_plus",   2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, ACC ? 8'd255 : 8'd2, 8'd100, 2'b01);
    add("dig_ana",     2'b00, 1'b1, 2'b01, 2'b00, 2'b01, 8'h03, 8'h00, ACC ? 8'd7 : 8'd12, 8'd100, 2'b01);
    add("ch_indep",    2'b00, 1'b1, 2'b00, 2'b01, 2'b10, 8'h00, 8'h14, ACC ? 8'd4 : 8'd8, 8'd140, 2'b11);
    add("minus_again", 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 8'h00, 8'h14, ACC ? 8'd0 : 8'd4, 8'd140, 2'b01);
    add("full_turn",   2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 8'h00, 8'h80, ACC ? 8'd0 : 8'd4, 8'd140, 2'b00);
    add("clamp_high",  2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 8'h00, 8'h3C, ACC ? 8'd0 : 8'd4, 8'd200, 2'b10);
    add("ch0_low",     2'b10, 1'b0, 2'b00, 2'b00, 2'b01, 8'hFE, 8'h3C, ACC ? 8'd252 : 8'd0, 8'd200, 2'b01);
    add("mode_switch", 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 8'hFE, 8'h3C, ACC ? 8'd252 : 8'd0, 8'd200, 2'b00);
    add("pull_in",     2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 8'hFE, 8'h3C, ACC ? 8'd200 : 8'd10, 8'd200, 2'b01);
    add("to_zero",     2'b10, 1'b0, 2'b00, 2'b00, 2'b01, ACC ? 8'h9C : 8'hFB, 8'h3C, 8'd0, 8'd200, 2'b01);
    for (int i = 0; i < 6; i++)
      add("ramp", 2'b10, 1'b1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00,
          ACC ? 8'(ramp_acc[i]) : 8'(4 * (i + 1)), 8'd200, 2'b01);
    add("both_held",   2'b10, 1'b1, 2'b01, 2'b01, 2'b00, 8'h00, 8'h00, ACC ? 8'd18 : 8'd24, 8'd200, 2'b00);
    add("plus_after",  2'b10, 1'b1, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, ACC ? 8'd19 : 8'd28, 8'd200, 2'b01);

    foreach (tbl[i]) begin
      @(negedge clk);
      mode = tbl[i].mode; strobe = tbl[i].strb; plus = tbl[i].plus; minus = tbl[i].minus;
      tog  = tog ^ tbl[i].tog; d0 = tbl[i].d0; d1 = tbl[i].d1;
      drive_spin();
      @(posedge clk); #1;
      chk({tbl[i].name, "_pos"}, spin_out, {tbl[i].exp1, tbl[i].exp0});
      chk({tbl[i].name, "_moved"}, moved, tbl[i].mv);
      @(negedge clk) strobe = 1'b0;
      @(posedge clk); #1;
      chk({tbl[i].name, "_hold_pos"}, spin_out, {tbl[i].exp1, tbl[i].exp0});
      chk({tbl[i].name, "_hold_moved"}, moved, 2'b00);
    end

    // Asynchronous reset right after an update: outputs drop immediately.
    @(negedge clk);
    strobe = 1'b1; plus = 2'b01; minus = 2'b00;
    @(posedge clk); #1;
    chk("pre_reset_moved", moved, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("async_reset_pos", spin_out, {8'(RV), 8'(RV)});
    chk("async_reset_moved", moved, 2'b00);
    @(negedge clk);
    strobe = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rearm_pos", spin_out, {8'(RV), 8'(RV)});

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      plus   = 2'($urandom);
      minus  = 2'($urandom);
      strobe = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      tog = tog ^ 2'($urandom);
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      drive_spin();
      @(posedge clk); #1;
      chk("rand_pos", spin_out, {8'(m_pos[1]), 8'(m_pos[0])});
      chk("rand_moved", moved, {m_mv[1], m_mv[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
